delay_line_ctrl: RTL and testbench

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

---
 rtl/delay_line_ctrl.sv | 148 ++++++++++++++
 tb/tb_delay_line_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
//   Feed-forward echo controller driving an external dual-port sample RAM.
//   Each accepted sample x produces out = sat(x + (mem[wr_ptr - delay] >>> FB_SHIFT)),
//   and x is then stored at wr_ptr. After reset or a clear request the whole
//   buffer is swept to zero, one location per cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clear             zero the buffer (honoured only while idle)
//   in_valid/in_ready/in_sample     input sample handshake
//   delay             delay in samples, 0 selects the full buffer size
//   out_valid/out_ready/out_sample  output sample handshake
//   busy              high during the clear sweep
//   mem_*             RAM master; port A writes, port B reads with 1-cycle latency
module delay_line_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int FB_SHIFT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic [ADDR_WIDTH-1:0] delay,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic [DATA_WIDTH-1:0] mem_data_a,
    output logic                  mem_we_a,
    output logic                  mem_we_b,
    input  logic [DATA_WIDTH-1:0] mem_q_b
);

    typedef enum logic [2:0] {
        CLR,
        IDLE,
        RD,
        WR,
        OUT
    } state_t;

    state_t                        state_q;
    logic        [ADDR_WIDTH-1:0]  clr_cnt_q;
    logic        [ADDR_WIDTH-1:0]  wr_ptr_q;
    logic        [ADDR_WIDTH-1:0]  rd_addr_q;
    logic signed [DATA_WIDTH-1:0]  x_q;
    logic signed [DATA_WIDTH-1:0]  d_q;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic                          busy_q;

    logic signed [DATA_WIDTH-1:0]  d_shift;
    logic signed [DATA_WIDTH:0]    sum;
    logic        [DATA_WIDTH-1:0]  out_sample_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLR;
            clr_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_addr_q   <= '0;
            x_q         <= '0;
            d_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                CLR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    // clear wins over a simultaneous input; that sample is not taken
                    if (clear) begin
                        state_q    <= CLR;
                        clr_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end else if (in_valid) begin
                        x_q        <= in_sample;
                        // modular subtraction: delay 0 lands on wr_ptr itself,
                        // which still holds the sample from SIZE writes ago
                        rd_addr_q  <= wr_ptr_q - delay;
                        in_ready_q <= 1'b0;
                        state_q    <= RD;
                    end
                end
                RD: begin
                    state_q <= WR;
                end
                WR: begin
                    d_q         <= mem_q_b;
                    wr_ptr_q    <= wr_ptr_q + 1'b1;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= CLR;
                    clr_cnt_q   <= '0;
                    busy_q      <= 1'b1;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mix is a pure function of x_q/d_q, both frozen while in OUT,
    // so out_sample holds steady under back-pressure.
    always_comb begin
        d_shift      = d_q >>> FB_SHIFT;
        sum          = {x_q[DATA_WIDTH-1], x_q} + {d_shift[DATA_WIDTH-1], d_shift};
        out_sample_d = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            out_sample_d = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign out_sample = out_sample_d;

    assign mem_we_a   = (state_q == CLR) || (state_q == WR);
    assign mem_addr_a = (state_q == CLR) ? clr_cnt_q : wr_ptr_q;
    assign mem_data_a = (state_q == CLR) ? '0 : x_q;
    assign mem_addr_b = rd_addr_q;
    assign mem_we_b   = 1'b0;

endmodule

// File: tb/tb_delay_line_ctrl.sv
module tb_delay_line_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sample;
    logic [3:0]  delay;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic        busy;
    logic [3:0]  mem_addr_a;
    logic [3:0]  mem_addr_b;
    logic [15:0] mem_data_a;
    logic        mem_we_a;
    logic        mem_we_b;
    logic [15:0] mem_q_b;
    logic        fill;

    logic [15:0] mem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    delay_line_ctrl #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4),
        .FB_SHIFT  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .delay     (delay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sample(out_sample),
        .busy      (busy),
        .mem_addr_a(mem_addr_a),
        .mem_addr_b(mem_addr_b),
        .mem_data_a(mem_data_a),
        .mem_we_a  (mem_we_a),
        .mem_we_b  (mem_we_b),
        .mem_q_b   (mem_q_b)
    );

    // dual-port RAM model: port A write, port B registered read
    always @(posedge clk) begin
        if (fill) begin
            for (int unsigned i = 0; i < 16; i++) mem[i] <= 16'h5A5A;
        end else begin
            if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
            mem_q_b <= mem[mem_addr_b];
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the output handshake.
    task automatic do_sample(input logic [15:0] s, input logic [3:0] d,
                             output logic [15:0] res, output int lat);
        int n = 0;
        lat = -1;
        res = 16'hxxxx;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b1;
        in_sample = s;
        delay     = d;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_sample = 16'h0000;
        delay     = ~d;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = c;
                res = out_sample;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt = 0;
        int nz  = 0;
        @(negedge clk);
        fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        pulse_reset();
        @(negedge clk);
        total += 5;
        if (busy !== 1'b1)        begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
        if (in_ready !== 1'b0)    begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_sample !== 16'h0) begin bad++; $display("FAIL reset_out_sample got=%0d exp=0", out_sample); end
        if (mem_we_b !== 1'b0)    begin bad++; $display("FAIL reset_we_b got=%b exp=0", mem_we_b); end
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) cnt++;
            else break;
            @(negedge clk);
        end
        for (int unsigned i = 0; i < 16; i++) if (mem[i] !== 16'h0) nz++;
        total += 3;
        if (cnt != 16)         begin bad++; $display("FAIL reset_busy_cycles got=%0d exp=16", cnt); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", in_ready); end
        if (nz != 0)           begin bad++; $display("FAIL reset_mem_zero nonzero_words=%0d exp=0", nz); end
    endtask

    task automatic test_delay2();
        int ins[4];
        int exps[4];
        logic [15:0] res;
        int lat;
        ins  = '{100, 200, 300, 400};
        exps = '{100, 200, 350, 500};
        for (int k = 0; k < 4; k++) begin
            do_sample(16'(ins[k]), 4'd2, res, lat);
            total += 2;
            if (res !== 16'(exps[k])) begin bad++; $display("FAIL delay2_out[%0d] got=%0d exp=%0d", k, $signed(res), exps[k]); end
            if (lat != 3)             begin bad++; $display("FAIL delay2_lat[%0d] got=%0d exp=3", k, lat); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] res;
        int lat;
        pulse_reset();
        wait_idle();
        do_sample(16'(32000), 4'd1, res, lat);
        total++;
        if (res !== 16'(32000))  begin bad++; $display("FAIL sat_pos0 got=%0d exp=32000", $signed(res)); end
        do_sample(16'(32000), 4'd1, res, lat);
        total++;
        if (res !== 16'(32767))  begin bad++; $display("FAIL sat_pos1 got=%0d exp=32767", $signed(res)); end
        pulse_reset();
        wait_idle();
        do_sample(16'(-32000), 4'd1, res, lat);
        total++;
        if (res !== 16'(-32000)) begin bad++; $display("FAIL sat_neg0 got=%0d exp=-32000", $signed(res)); end
        do_sample(16'(-32000), 4'd1, res, lat);
        total++;
        if (res !== 16'(-32768)) begin bad++; $display("FAIL sat_neg1 got=%0d exp=-32768", $signed(res)); end
    endtask

    task automatic test_wrap();
        logic [15:0] res;
        int lat;
        int exp_v;
        pulse_reset();
        wait_idle();
        for (int k = 1; k <= 20; k++) begin
            exp_v = (k <= 16) ? k : k + ((k - 16) >> 1);
            do_sample(16'(k), 4'd0, res, lat);
            total += 2;
            if (res !== 16'(exp_v)) begin bad++; $display("FAIL wrap_out[%0d] got=%0d exp=%0d", k, $signed(res), exp_v); end
            if (lat != 3)           begin bad++; $display("FAIL wrap_lat[%0d] got=%0d exp=3", k, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] res;
        int lat = -1;
        pulse_reset();
        wait_idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sample = 16'd1234;
        delay     = 4'd1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin lat = c; break; end
        end
        total++;
        if (lat != 3) begin bad++; $display("FAIL bp_lat got=%0d exp=3", lat); end
        in_valid  = 1'b1;
        in_sample = 16'd999;
        for (int i = 0; i < 5; i++) begin
            total += 3;
            if (out_valid !== 1'b1)      begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
            if (out_sample !== 16'd1234) begin bad++; $display("FAIL bp_sample[%0d] got=%0d exp=1234", i, out_sample); end
            if (in_ready !== 1'b0)       begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        do_sample(16'd10, 4'd1, res, lat);
        total++;
        if (res !== 16'd627) begin bad++; $display("FAIL bp_next got=%0d exp=627", $signed(res)); end
    endtask

    task automatic test_reset_in_out();
        logic [15:0] res;
        int lat = -1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sample = 16'd5;
        delay     = 4'd1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin lat = c; break; end
        end
        pulse_reset();
        @(negedge clk);
        total += 4;
        if (lat != 3)           begin bad++; $display("FAIL rio_lat got=%0d exp=3", lat); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rio_valid got=%b exp=0", out_valid); end
        if (busy !== 1'b1)      begin bad++; $display("FAIL rio_busy got=%b exp=1", busy); end
        if (in_ready !== 1'b0)  begin bad++; $display("FAIL rio_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        wait_idle();
        do_sample(16'd7, 4'd1, res, lat);
        total++;
        if (res !== 16'd7) begin bad++; $display("FAIL rio_after got=%0d exp=7", $signed(res)); end
    endtask

    task automatic test_clear();
        logic [15:0] res;
        int lat = -1;
        int cnt = 0;
        int nz  = 0;
        logic busy_seen = 1'b0;
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_sample = 16'd777;
        delay     = 4'd1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) cnt++;
            else break;
            @(negedge clk);
        end
        for (int unsigned i = 0; i < 16; i++) if (mem[i] !== 16'h0) nz++;
        total += 2;
        if (cnt != 16) begin bad++; $display("FAIL clr_busy_cycles got=%0d exp=16", cnt); end
        if (nz != 0)   begin bad++; $display("FAIL clr_mem_zero nonzero_words=%0d exp=0", nz); end
        do_sample(16'd50, 4'd1, res, lat);
        total++;
        if (res !== 16'd50) begin bad++; $display("FAIL clr_after got=%0d exp=50", $signed(res)); end
        // clear raised while a sample is in flight must be ignored
        in_valid  = 1'b1;
        in_sample = 16'd60;
        delay     = 4'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b1;
        lat      = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen = 1'b1;
            if (out_valid === 1'b1) begin lat = c; res = out_sample; break; end
        end
        clear = 1'b0;
        @(negedge clk);
        total += 3;
        if (lat != 3)         begin bad++; $display("FAIL clr_ign_lat got=%0d exp=3", lat); end
        if (busy_seen)        begin bad++; $display("FAIL clr_ign_busy got=1 exp=0"); end
        if (res !== 16'd85)   begin bad++; $display("FAIL clr_ign_out got=%0d exp=85", $signed(res)); end
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_sample = 16'h0;
        delay     = 4'd0;
        out_ready = 1'b1;
        fill      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();
        test_reset();
        test_delay2();
        test_saturation();
        test_wrap();
        test_backpressure();
        test_reset_in_out();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
